// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr,
                                     input logic [5:0]         opcode);
        return (instr[OPC_MSB:OPC_LSB] == opcode);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Output register holding the fetched instruction and its address.
// Clear wins over load so a redirect or restart never lets a stale capture through.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: sequential PC with redirect, decode back-pressure,
// halt-opcode detection and a saturating count of accepted instructions.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR  = 8'h00,
    parameter logic [5:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               out_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;

    logic w_start_ld;
    logic w_redirect;
    logic w_capture;
    logic w_clear;
    logic w_accept;
    logic w_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_capture && is_halt(mem_instr, HALT_OPCODE)) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output / control decode; start is only honoured outside RUN,
    // redirect only inside RUN, so start naturally beats redirect in HALT.
    always_comb begin
        w_start_ld = 1'b0;
        w_redirect = 1'b0;
        w_capture  = 1'b0;
        w_clear    = 1'b0;
        halted     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start_ld = start;
                w_clear    = start;
            end
            ST_RUN: begin
                w_redirect = redirect_valid;
                w_capture  = !redirect_valid && (!w_valid || out_ready);
                w_clear    = redirect_valid;
            end
            ST_HALT: begin
                halted     = 1'b1;
                w_start_ld = start;
                w_clear    = start || (w_valid && out_ready);
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= START_ADDR;
        end else if (w_start_ld) begin
            r_pc <= START_ADDR;
        end else if (w_redirect) begin
            r_pc <= redirect_addr;
        end else if (w_capture) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign w_accept = w_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= sat_inc(r_count);
        end
    end

    fetch_buffer u_buffer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_load  (w_capture),
        .i_instr (mem_instr),
        .i_pc    (r_pc),
        .o_valid (w_valid),
        .o_instr (instr),
        .o_pc    (instr_pc)
    );

    assign instr_valid = w_valid;
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign fetch_count = r_count;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h00: PC value loaded on reset and on start.
REQ-002 SHALL have parameter HALT_OPCODE, default 6'b111111: opcode in instruction bits [31:26] that stops fetching.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin fetching from START_ADDR; honoured in IDLE and HALT only.
REQ-006 SHALL have port mem_addr, output, 8: word address to instruction memory, driven combinationally from pc.
REQ-007 SHALL have port mem_instr, input, 32: combinational read data for mem_addr.
REQ-008 SHALL have port redirect_valid, input, 1: branch/jump request.
REQ-009 SHALL have port redirect_addr, input, 8: branch/jump target.
REQ-010 SHALL have port out_ready, input, 1: decode accepts instr this cycle.
REQ-011 SHALL have port instr_valid, output, 1: instr/instr_pc hold a fetched instruction.
REQ-012 SHALL have port instr, output, 32: fetched instruction.
REQ-013 SHALL have port instr_pc, output, 8: address instr was fetched from.
REQ-014 SHALL have port pc, output, 8: next fetch address.
REQ-015 SHALL have port halted, output, 1: high in HALT state.
REQ-016 SHALL have port fetch_count, output, 16: accepted-instruction count, saturating at 16'hFFFF.

Function
REQ-017 SHALL implement states IDLE, RUN, HALT; IDLE -start-> RUN; RUN -halt opcode captured-> HALT; HALT -start-> RUN.
REQ-018 SHALL, on start, load pc with START_ADDR and clear instr_valid.
REQ-019 SHALL, in RUN, capture mem_instr into instr, pc into instr_pc, set instr_valid and increment pc whenever the output register is empty or accepted (instr_valid=0 or out_ready=1) that cycle: one instruction per cycle at full throughput.
REQ-020 SHALL hold instr, instr_pc, instr_valid and pc unchanged while instr_valid=1 and out_ready=0 (no redirect).
REQ-021 SHALL increment pc modulo 256 (8'hFF wraps to 8'h00).
REQ-022 SHALL, on redirect_valid=1 in RUN, load pc with redirect_addr and clear instr_valid next cycle regardless of out_ready; redirect has priority over capture; the first target instruction becomes valid two cycles after the redirect.
REQ-023 SHALL, when a captured instruction has [31:26]=HALT_OPCODE, present it with instr_valid=1, enter HALT, and stop incrementing pc (pc = halt address + 1).
REQ-024 SHALL, in HALT, keep instr_valid until out_ready=1, then clear it; no further capture.
REQ-025 SHALL ignore redirect_valid in IDLE and HALT.
REQ-026 SHALL increment fetch_count on every cycle with instr_valid=1 and out_ready=1, saturating.
REQ-027 SHALL give start priority over redirect_valid when both are asserted in HALT.

Reset
REQ-028 SHALL, on reset, set state IDLE, pc=START_ADDR, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0; reset overrides start and redirect in the same cycle.
REQ-029 SHALL, on reset during RUN or HALT, discard any held instruction with no acceptance counted.

Structure
REQ-030 SHALL place the state enumeration, the 8-bit address width and the 32-bit instruction width constants, and the HALT_OPCODE default in a shared package fetch_pkg.
REQ-031 SHALL implement the output register (instr/instr_pc/instr_valid with hold logic) as one sub-module, fetch_buffer; the FSM and PC stay in fetch_controller.

Verification
REQ-032 SHALL cover: memory word0=32'h7E, word2=32'h5, word5=32'h3FF, other words 0; start with out_ready=1 -> instr 32'h7E, 0, 32'h5 on consecutive cycles with instr_pc 0,1,2.
REQ-033 SHALL cover: out_ready=0 for 3 cycles while instr_pc=2 -> instr stays 32'h5, pc stays 3, fetch_count unchanged; after release the next instr_pc is 3.
REQ-034 SHALL cover: redirect_valid with redirect_addr=5 while instr_valid=1, out_ready=0 -> instr_valid=0 next cycle, then instr=32'h3FF with instr_pc=5.
REQ-035 SHALL cover: word 4=32'hFC000000 -> instr_valid with instr_pc=4, halted=1, pc=5; after acceptance instr_valid=0 and stays 0; start -> fetch resumes at 0.
REQ-036 SHALL cover: redirect to 8'hFF -> instr_pc sequence FF, 00, 01 (wrap).
REQ-037 SHALL cover: reset asserted mid-RUN together with start -> state IDLE, all outputs at reset values, fetch_count=0.
